// File: rtl/istr_reg.sv
// rtl/istr_reg.sv - SDMAC interrupt status register with snapshot-on-read and read-clear
module istr_reg #(
    parameter int SYNC_STAGES = 2,
    parameter bit CLR_ON_READ = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       _CS,
    input  logic       _DS,
    input  logic       R_W,
    input  logic       INTEN,
    input  logic       SCSI_INT,
    input  logic       FIFO_FF,
    input  logic       FIFO_FE,
    input  logic       OVR_P,
    input  logic       UND_P,
    input  logic       TC_P,
    output logic [7:0] DOUT,
    output logic       DOE,
    output logic       _INT
);
    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {IDLE, SNAP, HOLD, CLEAR} state_t;

    state_t        state_q, state_d;
    logic [NS-1:0] cs_sync_q, cs_sync_d;
    logic [NS-1:0] ds_sync_q, ds_sync_d;
    logic [NS-1:0] rw_sync_q, rw_sync_d;
    logic [NS-1:0] si_sync_q, si_sync_d;
    logic [7:0]    snap_q, snap_d;
    logic          e_int_q, e_int_d;
    logic          ue_int_q, ue_int_d;
    logic          oe_int_q, oe_int_d;
    logic          int_n_q, int_n_d;

    logic          rd;
    logic          ints;
    logic          int_f;
    logic          int_p;
    logic [7:0]    status;
    logic [2:0]    clr_mask;

    always_comb begin
        cs_sync_d = {cs_sync_q[NS-2:0], _CS};
        ds_sync_d = {ds_sync_q[NS-2:0], _DS};
        rw_sync_d = {rw_sync_q[NS-2:0], R_W};
        si_sync_d = {si_sync_q[NS-2:0], SCSI_INT};

        rd     = ~cs_sync_q[NS-1] & ~ds_sync_q[NS-1] & rw_sync_q[NS-1];
        ints   = si_sync_q[NS-1];
        int_f  = ints | e_int_q | ue_int_q | oe_int_q;
        int_p  = int_f & INTEN;
        status = {int_f, ints, e_int_q, int_p, ue_int_q, oe_int_q, FIFO_FF, FIFO_FE};
    end

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        clr_mask = 3'b000;
        case (state_q)
            IDLE: begin
                if (rd) begin
                    state_d = SNAP;
                end
            end
            SNAP: begin
                snap_d  = status;
                state_d = HOLD;
            end
            HOLD: begin
                if (!rd) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                // Only sticky bits the CPU actually saw are cleared.
                if (CLR_ON_READ) begin
                    clr_mask = {snap_q[5], snap_q[3], snap_q[2]};
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A set pulse coinciding with the clear keeps the bit set.
        e_int_d  = (e_int_q  & ~clr_mask[2]) | TC_P;
        ue_int_d = (ue_int_q & ~clr_mask[1]) | UND_P;
        oe_int_d = (oe_int_q & ~clr_mask[0]) | OVR_P;
        int_n_d  = ~int_p;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cs_sync_q <= '1;
            ds_sync_q <= '1;
            rw_sync_q <= '0;
            si_sync_q <= '0;
            snap_q    <= 8'h00;
            e_int_q   <= 1'b0;
            ue_int_q  <= 1'b0;
            oe_int_q  <= 1'b0;
            int_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cs_sync_q <= cs_sync_d;
            ds_sync_q <= ds_sync_d;
            rw_sync_q <= rw_sync_d;
            si_sync_q <= si_sync_d;
            snap_q    <= snap_d;
            e_int_q   <= e_int_d;
            ue_int_q  <= ue_int_d;
            oe_int_q  <= oe_int_d;
            int_n_q   <= int_n_d;
        end
    end

    always_comb begin
        DOE  = (state_q == HOLD);
        DOUT = DOE ? snap_q : 8'h00;
        _INT = int_n_q;
    end
endmodule
